// File: rtl/ghr_checkpoint_ctrl_if.sv
// ghr_checkpoint_ctrl_if: prediction, resolution and status signals of the GHR checkpoint controller
interface ghr_checkpoint_ctrl_if #(
    parameter int GHR_LEN = 32,
    parameter int DEPTH   = 8,
    parameter int TAG_W   = $clog2(DEPTH)
);
    logic               i_pred_valid;
    logic               i_pred_taken;
    logic               o_pred_ready;
    logic [TAG_W-1:0]   o_pred_tag;
    logic [GHR_LEN-1:0] o_spec_ghr;
    logic [GHR_LEN-1:0] o_commit_ghr;
    logic               i_res_valid;
    logic [TAG_W-1:0]   i_res_tag;
    logic               i_res_outcome;
    logic               o_mispredict;
    logic               i_flush;
    logic [TAG_W:0]     o_count;
    logic               o_err;

    modport master (
        output i_pred_valid, i_pred_taken, i_res_valid, i_res_tag, i_res_outcome, i_flush,
        input  o_pred_ready, o_pred_tag, o_spec_ghr, o_commit_ghr, o_mispredict, o_count, o_err
    );

    modport slave (
        input  i_pred_valid, i_pred_taken, i_res_valid, i_res_tag, i_res_outcome, i_flush,
        output o_pred_ready, o_pred_tag, o_spec_ghr, o_commit_ghr, o_mispredict, o_count, o_err
    );
endinterface

// File: rtl/ghr_checkpoint_ctrl.sv
// ghr_checkpoint_ctrl: speculative/committed GHR with an in-order checkpoint queue of predicted directions
module ghr_checkpoint_ctrl #(
    parameter int GHR_LEN = 32,
    parameter int DEPTH   = 8,
    parameter int TAG_W   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    ghr_checkpoint_ctrl_if.slave bus
);
    logic [TAG_W-1:0]   r_head;
    logic [TAG_W-1:0]   r_tail;
    logic [TAG_W:0]     r_count;
    logic [DEPTH-1:0]   r_pred;
    logic [GHR_LEN-1:0] r_spec;
    logic [GHR_LEN-1:0] r_commit;
    logic               r_mis;
    logic               r_err;

    logic               w_ready;
    logic               w_push;
    logic               w_res_ok;
    logic               w_mis;
    logic               w_drop;
    logic [GHR_LEN-1:0] w_commit_nx;
    logic [TAG_W-1:0]   w_head_nx;

    // Ready depends only on occupancy; a resolve is accepted only for the oldest in-flight branch
    always_comb begin
        w_ready     = r_count != (TAG_W+1)'(DEPTH);
        w_push      = bus.i_pred_valid & w_ready;
        w_res_ok    = bus.i_res_valid & (r_count != '0) & (bus.i_res_tag == r_head);
        w_mis       = w_res_ok & (bus.i_res_outcome != r_pred[r_head]);
        w_drop      = bus.i_flush | w_mis;
        w_commit_nx = w_res_ok ? {r_commit[GHR_LEN-2:0], bus.i_res_outcome} : r_commit;
        w_head_nx   = w_res_ok ? r_head + TAG_W'(1) : r_head;
    end

    // Commit side always advances first; a flush or mispredict then rebuilds speculation from it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_spec   <= '0;
            r_commit <= '0;
            r_mis    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_commit <= w_commit_nx;
            r_head   <= w_head_nx;
            r_mis    <= w_mis;
            r_err    <= r_err | (bus.i_res_valid & ~w_res_ok);
            if (w_drop) begin
                r_spec  <= w_commit_nx;
                r_tail  <= w_head_nx;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_pred[r_tail] <= bus.i_pred_taken;
                    r_tail         <= r_tail + TAG_W'(1);
                    r_spec         <= {r_spec[GHR_LEN-2:0], bus.i_pred_taken};
                end
                r_count <= r_count + (TAG_W+1)'(w_push) - (TAG_W+1)'(w_res_ok);
            end
        end
    end

    assign bus.o_pred_ready = w_ready;
    assign bus.o_pred_tag   = r_tail;
    assign bus.o_spec_ghr   = r_spec;
    assign bus.o_commit_ghr = r_commit;
    assign bus.o_mispredict = r_mis;
    assign bus.o_count      = r_count;
    assign bus.o_err        = r_err;
endmodule

// File: tb/tb_ghr_checkpoint_ctrl.sv
// tb_ghr_checkpoint_ctrl: directed vector table, tag-wrap sequence and randomized model comparison
module tb_ghr_checkpoint_ctrl;
    localparam int GL = 8;
    localparam int DP = 4;
    localparam int TW = 2;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ghr_checkpoint_ctrl_if #(.GHR_LEN(GL), .DEPTH(DP), .TAG_W(TW)) bus ();

    ghr_checkpoint_ctrl #(.GHR_LEN(GL), .DEPTH(DP), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst, pv, pt, rv;
        logic [1:0] rtag;
        logic       ro, fl;
        logic [7:0] spec, commit;
        logic [2:0] cnt;
        logic       rdy;
        logic [1:0] tag;
        logic       mis, err;
    } vec_t;

    typedef struct {
        logic [1:0] tag;
        logic       p;
    } ent_t;

    vec_t tbl[$];
    ent_t mq[$];
    int   mh, mt;
    logic [7:0] ms, mc;
    logic mm, me;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic drive(input logic r, pv, pt, rv, input logic [1:0] rt, input logic ro, fl);
        rst               = r;
        bus.i_pred_valid  = pv;
        bus.i_pred_taken  = pt;
        bus.i_res_valid   = rv;
        bus.i_res_tag     = rt;
        bus.i_res_outcome = ro;
        bus.i_flush       = fl;
    endtask

    task automatic check_all(input string c, input logic [7:0] s, cm, input logic [2:0] n,
                             input logic rd, input logic [1:0] t, input logic mi, er);
        chk({c, " spec"},   32'(bus.o_spec_ghr),   32'(s));
        chk({c, " commit"}, 32'(bus.o_commit_ghr), 32'(cm));
        chk({c, " count"},  32'(bus.o_count),      32'(n));
        chk({c, " ready"},  32'(bus.o_pred_ready), 32'(rd));
        chk({c, " tag"},    32'(bus.o_pred_tag),   32'(t));
        chk({c, " mis"},    32'(bus.o_mispredict), 32'(mi));
        chk({c, " err"},    32'(bus.o_err),        32'(er));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        mh = 0; mt = 0; ms = '0; mc = '0; mm = 1'b0; me = 1'b0;
    endtask

    task automatic model_step(input logic r, pv, pt, rv, input logic [1:0] rt, input logic ro, fl);
        bit push, ok, wrong;
        if (r) begin
            model_reset();
            return;
        end
        push  = pv && (mq.size() != DP);
        ok    = rv && (mq.size() != 0) && (mq.size() != 0 ? mq[0].tag == rt : 1'b0);
        wrong = 1'b0;
        if (rv && !ok) me = 1'b1;
        if (ok) begin
            mc    = {mc[6:0], ro};
            wrong = ro != mq[0].p;
            void'(mq.pop_front());
            mh = (mh + 1) % DP;
        end
        mm = wrong;
        if (fl || wrong) begin
            ms = mc;
            mq.delete();
            mt = mh;
        end else if (push) begin
            mq.push_back('{tag: 2'(mt), p: pt});
            mt = (mt + 1) % DP;
            ms = {ms[6:0], pt};
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check_all("reset", 8'h00, 8'h00, 0, 1, 0, 0, 0);

        //            rst pv pt rv rt ro fl   spec   commit cnt rdy tag mis err
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 8'h01, 8'h00, 1, 1, 1, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 8'h02, 8'h00, 2, 1, 2, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 8'h05, 8'h00, 3, 1, 3, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0, 1, 0, 8'h05, 8'h01, 2, 1, 3, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 1, 1, 0, 8'h03, 8'h03, 0, 1, 2, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 8'h03, 8'h03, 0, 1, 2, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 8'h01, 8'h00, 1, 1, 1, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 8'h03, 8'h00, 2, 1, 2, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 8'h07, 8'h00, 3, 1, 3, 0, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 8'h0F, 8'h00, 4, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 8'h0F, 8'h00, 4, 0, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 0, 1, 0, 8'h0F, 8'h01, 3, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 1, 1, 0, 8'h1E, 8'h03, 3, 1, 1, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 2, 0, 0, 8'h06, 8'h06, 0, 1, 3, 1, 0});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 8'h0D, 8'h06, 1, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 8'h1A, 8'h06, 2, 1, 1, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 1, 1, 0, 8'h35, 8'h06, 3, 1, 2, 0, 1});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 1, 8'h06, 8'h06, 0, 1, 3, 0, 1});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 8'h0D, 8'h06, 1, 1, 0, 0, 1});
        tbl.push_back('{0, 1, 1, 1, 3, 1, 1, 8'h0D, 8'h0D, 0, 1, 0, 0, 1});
        tbl.push_back('{1, 1, 1, 1, 0, 1, 1, 8'h00, 8'h00, 0, 1, 0, 0, 0});

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].pv, tbl[i].pt, tbl[i].rv, tbl[i].rtag, tbl[i].ro, tbl[i].fl);
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].spec, tbl[i].commit, tbl[i].cnt,
                      tbl[i].rdy, tbl[i].tag, tbl[i].mis, tbl[i].err);
        end

        // Tag wrap: one in flight, every cycle push T while resolving the previous branch as T
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 1, i > 0, 2'((i + 3) % DP), 1, 0);
            tick();
            chk($sformatf("wrap%0d tag", i), 32'(bus.o_pred_tag), 32'((i + 1) % DP));
            chk($sformatf("wrap%0d count", i), 32'(bus.o_count), 32'd1);
            chk($sformatf("wrap%0d commit", i), 32'(bus.o_commit_ghr), 32'(((1 << i) - 1) & 8'hFF));
        end

        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        model_reset();
        for (int i = 0; i < 800; i++) begin
            logic r, pv, pt, rv, ro, fl;
            logic [1:0] rt;
            r  = ($urandom_range(0, 99) == 0);
            pv = $urandom_range(0, 1);
            pt = $urandom_range(0, 1);
            fl = ($urandom_range(0, 19) == 0);
            rv = !fl && ($urandom_range(0, 9) < 4);
            ro = $urandom_range(0, 1);
            rt = (mq.size() != 0 && $urandom_range(0, 9) < 8) ? mq[0].tag : 2'($urandom_range(0, 3));
            model_step(r, pv, pt, rv, rt, ro, fl);
            drive(r, pv, pt, rv, rt, ro, fl);
            tick();
            check_all($sformatf("rnd%0d", i), ms, mc, 3'(mq.size()), mq.size() != DP, 2'(mt), mm, me);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
